// File: rtl/tinyml_ci_pkg.sv
// Shared types and constants for the tinyML custom-instruction router.
package tinyml_ci_pkg;

    localparam int CI_FID_W     = 10;
    localparam int CI_DATA_W    = 32;
    localparam int CI_SEL_W_MAX = 4;
    localparam logic [CI_DATA_W-1:0] CI_ERR_RSP = 32'hDEAD_C0DE;

    // One in-flight command: which slave owes the response, or an error marker.
    typedef struct packed {
        logic                    err;
        logic [CI_SEL_W_MAX-1:0] id;
    } ci_ord_t;

endpackage

// File: rtl/tinyml_ci_ord_fifo.sv
// In-order FIFO of issued-command records; head is the next response owed to the CPU.
module tinyml_ci_ord_fifo
    import tinyml_ci_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  ci_ord_t                din,
    input  logic                   pop,
    output ci_ord_t                dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    ci_ord_t            mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;

    // Entry storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == (PTR_W+1)'(DEPTH));
    assign empty = (count_r == (PTR_W+1)'(0));

endmodule

// File: rtl/tinyml_ci_router_chk.sv
// Simulation-only protocol checks for the custom-instruction router.
module tinyml_ci_router_chk
    import tinyml_ci_pkg::*;
#(
    parameter int NUM_SLV = 2
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 push,
    input logic                 pop,
    input logic                 full,
    input logic                 empty,
    input logic                 rsp_valid,
    input logic                 rsp_ready,
    input logic [CI_DATA_W-1:0] rsp_outputs_0,
    input logic [NUM_SLV-1:0]   slv_cmd_valid
);

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

    a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !rsp_ready && !reset) |=> $stable(rsp_outputs_0));

    a_one_strobe: assert property (@(posedge clk) disable iff (reset) $onehot0(slv_cmd_valid));

endmodule

// File: rtl/tinyml_ci_router.sv
// Routes CPU custom-instruction commands to NUM_SLV slaves and returns
// responses strictly in issue order through one registered output stage.
module tinyml_ci_router
    import tinyml_ci_pkg::*;
#(
    parameter int                   NUM_SLV = 2,
    parameter int                   SEL_LSB = 9,
    parameter int                   SEL_W   = 1,
    parameter int                   MAX_OUT = 4,
    parameter logic [CI_DATA_W-1:0] ERR_RSP = CI_ERR_RSP
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    input  logic [CI_FID_W-1:0]            cmd_function_id,
    input  logic [CI_DATA_W-1:0]           cmd_inputs_0,
    input  logic [CI_DATA_W-1:0]           cmd_inputs_1,
    output logic                           cmd_ready,
    output logic                           rsp_valid,
    output logic [CI_DATA_W-1:0]           rsp_outputs_0,
    input  logic                           rsp_ready,
    output logic                           cmd_int,
    input  logic [NUM_SLV-1:0]             slv_int,
    output logic [NUM_SLV-1:0]             slv_cmd_valid,
    input  logic [NUM_SLV-1:0]             slv_cmd_ready,
    output logic [CI_FID_W-1:0]            slv_cmd_function_id,
    output logic [CI_DATA_W-1:0]           slv_cmd_inputs_0,
    output logic [CI_DATA_W-1:0]           slv_cmd_inputs_1,
    input  logic [NUM_SLV-1:0]             slv_rsp_valid,
    input  logic [CI_DATA_W*NUM_SLV-1:0]   slv_rsp_outputs_0,
    output logic [NUM_SLV-1:0]             slv_rsp_ready,
    output logic [$clog2(MAX_OUT):0]       outstanding
);

    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic [SEL_W-1:0]     sel_s;
    logic                 mapped_s;
    logic                 sel_ready_s;
    logic                 push_s;
    logic                 load_s;
    logic                 can_load_s;
    logic                 head_rsp_valid_s;
    logic                 full_s;
    logic                 empty_s;
    logic [CNT_W-1:0]     count_s;
    ci_ord_t              push_ord_s;
    ci_ord_t              head_ord_s;
    logic [CI_DATA_W-1:0] head_data_s;
    logic [CI_DATA_W-1:0] load_data_s;
    logic                 ovalid_r;
    logic [CI_DATA_W-1:0] odata_r;

    assign sel_s    = cmd_function_id[SEL_LSB +: SEL_W];
    assign mapped_s = (32'(sel_s) < 32'(NUM_SLV));

    // Issue side: strobe the selected slave; unmapped selects only need FIFO room.
    always_comb begin
        sel_ready_s   = 1'b0;
        slv_cmd_valid = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (mapped_s && (sel_s == SEL_W'(i))) begin
                sel_ready_s      = slv_cmd_ready[i];
                slv_cmd_valid[i] = cmd_valid && !full_s;
            end else begin
                slv_cmd_valid[i] = 1'b0;
            end
        end
        if (mapped_s) begin
            cmd_ready = !full_s && sel_ready_s;
        end else begin
            cmd_ready = !full_s;
        end
        push_s         = cmd_valid && cmd_ready;
        push_ord_s.err = !mapped_s;
        push_ord_s.id  = CI_SEL_W_MAX'(sel_s);
    end

    // Retire side: only the slave owning the FIFO head may hand over its response.
    always_comb begin
        can_load_s       = !ovalid_r || rsp_ready;
        slv_rsp_ready    = '0;
        head_rsp_valid_s = 1'b0;
        head_data_s      = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!empty_s && !head_ord_s.err && (head_ord_s.id == CI_SEL_W_MAX'(i))) begin
                slv_rsp_ready[i] = can_load_s;
                head_rsp_valid_s = slv_rsp_valid[i];
                head_data_s      = slv_rsp_outputs_0[CI_DATA_W*i +: CI_DATA_W];
            end else begin
                slv_rsp_ready[i] = 1'b0;
            end
        end
        if (empty_s) begin
            load_s      = 1'b0;
            load_data_s = head_data_s;
        end else if (head_ord_s.err) begin
            load_s      = can_load_s;
            load_data_s = ERR_RSP;
        end else begin
            load_s      = head_rsp_valid_s && can_load_s;
            load_data_s = head_data_s;
        end
    end

    // Output register; a load wins over a plain drain so back-to-back retirement works.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovalid_r <= 1'b0;
            odata_r  <= '0;
        end else if (load_s) begin
            ovalid_r <= 1'b1;
            odata_r  <= load_data_s;
        end else if (rsp_ready) begin
            ovalid_r <= 1'b0;
        end else begin
            ovalid_r <= ovalid_r;
        end
    end

    tinyml_ci_ord_fifo #(
        .DEPTH (MAX_OUT)
    ) u_ord_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (push_ord_s),
        .pop   (load_s),
        .dout  (head_ord_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    tinyml_ci_router_chk #(
        .NUM_SLV (NUM_SLV)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .push          (push_s),
        .pop           (load_s),
        .full          (full_s),
        .empty         (empty_s),
        .rsp_valid     (ovalid_r),
        .rsp_ready     (rsp_ready),
        .rsp_outputs_0 (odata_r),
        .slv_cmd_valid (slv_cmd_valid)
    );

    assign rsp_valid           = ovalid_r;
    assign rsp_outputs_0       = odata_r;
    assign outstanding         = count_s;
    assign cmd_int             = |slv_int;
    assign slv_cmd_function_id = cmd_function_id;
    assign slv_cmd_inputs_0    = cmd_inputs_0;
    assign slv_cmd_inputs_1    = cmd_inputs_1;

endmodule

// File: tb/tb_tinyml_ci_router.sv
// Directed bench: default two-slave router plus a three-slave variant for the unmapped path.
module tb_tinyml_ci_router;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          failures = 0;

    // default configuration
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, cmd_int;
    logic [9:0]  fid, slv_fid;
    logic [31:0] in0, in1, slv_in0, slv_in1, rsp_data;
    logic [1:0]  slv_int, slv_cmd_valid, slv_cmd_ready, slv_rsp_valid, slv_rsp_ready;
    logic [63:0] slv_rsp_data;
    logic [2:0]  outstanding;

    // three-slave configuration
    logic        u_cmd_valid, u_cmd_ready, u_rsp_valid, u_rsp_ready, u_cmd_int;
    logic [9:0]  u_fid, u_slv_fid;
    logic [31:0] u_slv_in0, u_slv_in1, u_rsp_data;
    logic [2:0]  u_slv_int, u_slv_cmd_valid, u_slv_cmd_ready, u_slv_rsp_valid, u_slv_rsp_ready;
    logic [95:0] u_slv_rsp_data;
    logic [2:0]  u_outstanding;

    always #5 clk = ~clk;

    tinyml_ci_router dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_function_id     (fid),
        .cmd_inputs_0        (in0),
        .cmd_inputs_1        (in1),
        .cmd_ready           (cmd_ready),
        .rsp_valid           (rsp_valid),
        .rsp_outputs_0       (rsp_data),
        .rsp_ready           (rsp_ready),
        .cmd_int             (cmd_int),
        .slv_int             (slv_int),
        .slv_cmd_valid       (slv_cmd_valid),
        .slv_cmd_ready       (slv_cmd_ready),
        .slv_cmd_function_id (slv_fid),
        .slv_cmd_inputs_0    (slv_in0),
        .slv_cmd_inputs_1    (slv_in1),
        .slv_rsp_valid       (slv_rsp_valid),
        .slv_rsp_outputs_0   (slv_rsp_data),
        .slv_rsp_ready       (slv_rsp_ready),
        .outstanding         (outstanding)
    );

    tinyml_ci_router #(
        .NUM_SLV (3),
        .SEL_LSB (8),
        .SEL_W   (2)
    ) dut3 (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (u_cmd_valid),
        .cmd_function_id     (u_fid),
        .cmd_inputs_0        (in0),
        .cmd_inputs_1        (in1),
        .cmd_ready           (u_cmd_ready),
        .rsp_valid           (u_rsp_valid),
        .rsp_outputs_0       (u_rsp_data),
        .rsp_ready           (u_rsp_ready),
        .cmd_int             (u_cmd_int),
        .slv_int             (u_slv_int),
        .slv_cmd_valid       (u_slv_cmd_valid),
        .slv_cmd_ready       (u_slv_cmd_ready),
        .slv_cmd_function_id (u_slv_fid),
        .slv_cmd_inputs_0    (u_slv_in0),
        .slv_cmd_inputs_1    (u_slv_in1),
        .slv_rsp_valid       (u_slv_rsp_valid),
        .slv_rsp_outputs_0   (u_slv_rsp_data),
        .slv_rsp_ready       (u_slv_rsp_ready),
        .outstanding         (u_outstanding)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; fid = 10'h000; in0 = 32'h0; in1 = 32'h0;
        rsp_ready = 1'b1; slv_int = 2'b00; slv_cmd_ready = 2'b11;
        slv_rsp_valid = 2'b00; slv_rsp_data = 64'h0;
        u_cmd_valid = 1'b0; u_fid = 10'h000; u_rsp_ready = 1'b1; u_slv_int = 3'b000;
        u_slv_cmd_ready = 3'b000; u_slv_rsp_valid = 3'b000; u_slv_rsp_data = 96'h0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset_outstanding", 64'(outstanding), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_u_outstanding", 64'(u_outstanding), 64'd0);

        // interrupt OR is combinational
        slv_int = 2'b10; #1;
        chk("cmd_int_set", 64'(cmd_int), 64'd1);
        slv_int = 2'b00; #1;
        chk("cmd_int_clr", 64'(cmd_int), 64'd0);

        // out-of-order slave responses are retired in issue order
        cmd_valid = 1'b1; fid = 10'h005; in0 = 32'hA5A5_0001; in1 = 32'h5A5A_0002; #1;
        chk("t1_strobe_s0", 64'(slv_cmd_valid), 64'h1);
        chk("t1_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t1_bcast_fid", 64'(slv_fid), 64'h005);
        chk("t1_bcast_in0", 64'(slv_in0), 64'hA5A5_0001);
        chk("t1_bcast_in1", 64'(slv_in1), 64'h5A5A_0002);
        step();
        chk("t1_out_1", 64'(outstanding), 64'd1);
        fid = 10'h205; #1;
        chk("t1_strobe_s1", 64'(slv_cmd_valid), 64'h2);
        step();
        cmd_valid = 1'b0; #1;
        chk("t1_out_2", 64'(outstanding), 64'd2);
        slv_rsp_valid = 2'b10; slv_rsp_data = {32'h22, 32'h0}; #1;
        chk("t1_s1_held", 64'(slv_rsp_ready), 64'h1);
        step();
        chk("t1_no_rsp", 64'(rsp_valid), 64'd0);
        chk("t1_out_still2", 64'(outstanding), 64'd2);
        slv_rsp_valid = 2'b11; slv_rsp_data = {32'h22, 32'h11};
        step();
        slv_rsp_valid = 2'b10; #1;
        chk("t1_rsp1_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp1_data", 64'(rsp_data), 64'h11);
        chk("t1_out_after1", 64'(outstanding), 64'd1);
        chk("t1_s1_now_ready", 64'(slv_rsp_ready), 64'h2);
        step();
        slv_rsp_valid = 2'b00; #1;
        chk("t1_rsp2_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp2_data", 64'(rsp_data), 64'h22);
        chk("t1_out_empty", 64'(outstanding), 64'd0);
        chk("t1_empty_no_ready", 64'(slv_rsp_ready), 64'h0);
        step();
        chk("t1_drained", 64'(rsp_valid), 64'd0);

        // fill to MAX_OUT with responses withheld
        cmd_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            fid = 10'(i);
            step();
            chk("t2_fill", 64'(outstanding), 64'(i));
        end
        fid = 10'h006; #1;
        chk("t2_full_blocks", 64'(cmd_ready), 64'd0);
        chk("t2_full_no_strobe", 64'(slv_cmd_valid), 64'h0);
        step();
        chk("t2_still_full", 64'(outstanding), 64'd4);
        slv_rsp_valid = 2'b01; slv_rsp_data = {32'h0, 32'h33}; #1;
        chk("t2_pop_no_bypass", 64'(cmd_ready), 64'd0);
        chk("t2_s0_ready", 64'(slv_rsp_ready), 64'h1);
        step();
        slv_rsp_valid = 2'b00; #1;
        chk("t2_out_3", 64'(outstanding), 64'd3);
        chk("t2_ready_back", 64'(cmd_ready), 64'd1);
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rsp_data", 64'(rsp_data), 64'h33);
        step();
        cmd_valid = 1'b0; #1;
        chk("t2_refill", 64'(outstanding), 64'd4);
        chk("t2_rsp_cleared", 64'(rsp_valid), 64'd0);

        // CPU back-pressure holds the output register, then back-to-back retirement
        rsp_ready = 1'b0; slv_rsp_valid = 2'b01; slv_rsp_data = {32'h0, 32'h44};
        step();
        slv_rsp_data = {32'h0, 32'h55}; #1;
        chk("t4_loaded_valid", 64'(rsp_valid), 64'd1);
        chk("t4_loaded_data", 64'(rsp_data), 64'h44);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stall_valid", 64'(rsp_valid), 64'd1);
            chk("t4_stall_data", 64'(rsp_data), 64'h44);
            chk("t4_stall_slv_ready", 64'(slv_rsp_ready), 64'h0);
            chk("t4_stall_out", 64'(outstanding), 64'd3);
        end
        rsp_ready = 1'b1; #1;
        chk("t4_release_ready", 64'(slv_rsp_ready), 64'h1);
        step();
        slv_rsp_data = {32'h0, 32'h66}; #1;
        chk("t4_b2b1_valid", 64'(rsp_valid), 64'd1);
        chk("t4_b2b1_data", 64'(rsp_data), 64'h55);
        chk("t4_b2b1_out", 64'(outstanding), 64'd2);
        step();
        slv_rsp_valid = 2'b00; rsp_ready = 1'b0; #1;
        chk("t4_b2b2_valid", 64'(rsp_valid), 64'd1);
        chk("t4_b2b2_data", 64'(rsp_data), 64'h66);
        chk("t4_b2b2_out", 64'(outstanding), 64'd1);

        // reset with entries in flight and a held response
        cmd_valid = 1'b1; fid = 10'h007;
        step();
        fid = 10'h008;
        step();
        cmd_valid = 1'b0; #1;
        chk("t5_pre_out", 64'(outstanding), 64'd3);
        chk("t5_pre_valid", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; #1;
        chk("t5_rst_out", 64'(outstanding), 64'd0);
        chk("t5_rst_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rst_data", 64'(rsp_data), 64'd0);
        cmd_valid = 1'b1; fid = 10'h205; #1;
        chk("t5_new_ready", 64'(cmd_ready), 64'd1);
        chk("t5_new_strobe", 64'(slv_cmd_valid), 64'h2);
        step();
        cmd_valid = 1'b0; #1;
        chk("t5_new_out", 64'(outstanding), 64'd1);
        rsp_ready = 1'b1; slv_rsp_valid = 2'b10; slv_rsp_data = {32'h99, 32'h0}; #1;
        chk("t5_s1_ready", 64'(slv_rsp_ready), 64'h2);
        step();
        slv_rsp_valid = 2'b00; #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t5_rsp_data", 64'(rsp_data), 64'h99);
        chk("t5_out_zero", 64'(outstanding), 64'd0);
        step();

        // unmapped select on the three-slave variant
        u_cmd_valid = 1'b1; u_fid = 10'h300; #1;
        chk("t3_no_strobe", 64'(u_slv_cmd_valid), 64'h0);
        chk("t3_ready", 64'(u_cmd_ready), 64'd1);
        step();
        u_cmd_valid = 1'b0; #1;
        chk("t3_out_1", 64'(u_outstanding), 64'd1);
        chk("t3_not_yet", 64'(u_rsp_valid), 64'd0);
        chk("t3_no_slv_ready", 64'(u_slv_rsp_ready), 64'h0);
        step();
        chk("t3_err_valid", 64'(u_rsp_valid), 64'd1);
        chk("t3_err_data", 64'(u_rsp_data), 64'hDEAD_C0DE);
        chk("t3_out_0", 64'(u_outstanding), 64'd0);
        u_cmd_valid = 1'b1; u_fid = 10'h200; #1;
        chk("t3_s2_strobe", 64'(u_slv_cmd_valid), 64'h4);
        chk("t3_s2_not_ready", 64'(u_cmd_ready), 64'd0);
        u_slv_cmd_ready = 3'b100; #1;
        chk("t3_s2_ready", 64'(u_cmd_ready), 64'd1);
        u_cmd_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinyml_ci_router.md
Name: tinyml_ci_router

Overview:
- Routes the CPU custom-instruction command stream to NUM_SLV custom-instruction slaves. Slave 0 is the tinyML accelerator; the others are user custom instructions.
- The slave is selected by a field of cmd_function_id.
- Tracks up to MAX_OUT outstanding commands in an in-order ID FIFO and returns responses strictly in issue order through a registered response stage.
- Generates an error response for unmapped function IDs and ORs slave interrupts. Sits between the CPU custom-instruction port and the slave blocks.

Parameters:
- NUM_SLV, 2: number of slaves; must be ≤ 2**SEL_W.
- SEL_LSB, 9: LSB of the slave-select field in cmd_function_id.
- SEL_W, 1: width of the slave-select field.
- MAX_OUT, 4: outstanding-command FIFO depth; power of 2, ≥ 2.
- ERR_RSP, 32'hDEAD_C0DE: rsp_outputs_0 value returned for an unmapped select.

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  CPU command valid
- cmd_function_id  in  10  function ID
- cmd_inputs_0  in  32  operand 0
- cmd_inputs_1  in  32  operand 1
- cmd_ready  out  1  command accepted
- rsp_valid  out  1  registered response valid
- rsp_outputs_0  out  32  response data
- rsp_ready  in  1  CPU response ready
- cmd_int  out  1  OR of slv_int
- slv_cmd_valid  out  NUM_SLV  per-slave command valid
- slv_cmd_ready  in  NUM_SLV  per-slave command ready
- slv_cmd_function_id  out  10  broadcast of cmd_function_id
- slv_cmd_inputs_0  out  32  broadcast of cmd_inputs_0
- slv_cmd_inputs_1  out  32  broadcast of cmd_inputs_1
- slv_rsp_valid  in  NUM_SLV  per-slave response valid
- slv_rsp_outputs_0  in  32*NUM_SLV  packed response data; slave i at [32i+31:32i]
- slv_rsp_ready  out  NUM_SLV  per-slave response ready
- outstanding  out  $clog2(MAX_OUT)+1  FIFO occupancy

Behaviour:
- Reset (sync, active-high), takes effect the cycle after reset is sampled high:
  - FIFO cleared; outstanding = 0; rsp_valid = 0; rsp_outputs_0 = 0.
  - Mid-operation reset discards all in-flight entries. Slaves share the reset.
- sel = cmd_function_id[SEL_LSB +: SEL_W]; mapped = (sel < NUM_SLV).
- Issue rules:
  - fifo_full = (outstanding == MAX_OUT).
  - Mapped: cmd_ready = !fifo_full & slv_cmd_ready[sel]; slv_cmd_valid[sel] = cmd_valid & !fifo_full; all other slv_cmd_valid bits are 0.
  - Unmapped: cmd_ready = !fifo_full; no slave is strobed.
  - cmd_ready does not depend on a same-cycle pop, so a full FIFO blocks issue even while retiring.
- On cmd_valid & cmd_ready, push {err = !mapped, id = sel} to the FIFO.
- Response stage: one output register (ovalid, odata).
  - can_load = !ovalid | rsp_ready.
  - Head entry h valid and h.err = 0: slv_rsp_ready[h.id] = can_load; all other slv_rsp_ready bits are 0. When slv_rsp_valid[h.id] & can_load: load odata = slave data, pop.
  - Head entry with h.err = 1: when can_load, load odata = ERR_RSP, pop. No slave is involved.
  - A slave whose response is not at the head sees slv_rsp_ready = 0 and is stalled.
  - ovalid clears on rsp_ready with no load in the same cycle. If a load and rsp_ready coincide, ovalid stays 1 with the new data.
- Latency:
  - Slave rsp handshake to rsp_valid = 1 cycle.
  - Unmapped command accept to rsp_valid = 2 cycles (push, then pop/load), assuming no earlier entries.
  - Full throughput is one response per cycle when rsp_ready is held high.
- Counter: outstanding += push, -= pop. A simultaneous push and pop leaves it unchanged. Pointers wrap modulo MAX_OUT.
- Empty FIFO: all slv_rsp_ready = 0. A spurious slv_rsp_valid is ignored and is a bench assertion error.
- cmd_int is combinational: |slv_int. slv_cmd_* data outputs are combinational broadcasts.
- Assertions (sim only):
  - no push when full; no pop when empty;
  - rsp_outputs_0 stable while rsp_valid & !rsp_ready;
  - at most one slv_cmd_valid bit high.

Decomposition:
- Package tinyml_ci_pkg:
  - CI_FID_W = 10, CI_DATA_W = 32, CI_ERR_RSP default;
  - struct ci_ord_t {logic err; logic [SEL_W-1:0] id}.
- One sub-module: tinyml_ci_ord_fifo, a synchronous FIFO of ci_ord_t with count, full and empty outputs.
- The response register and selection muxing stay in the top.

Test Plan:
- Defaults: issue fid 0x005 then 0x205. Slave 1 responds 0x22 before slave 0 responds 0x11 → slave 1 is held (slv_rsp_ready[1] = 0) until slave 0 retires; CPU sees 0x11 then 0x22.
- Issue 4 commands to slave 0 while its responses are withheld → outstanding = 4, cmd_ready = 0 on the 5th. Release one response → cmd_ready returns the cycle after outstanding drops to 3.
- SEL_LSB = 8, SEL_W = 2, NUM_SLV = 3: issue fid 0x300 → no slv_cmd_valid; rsp_valid 2 cycles after accept with 0xDEAD_C0DE.
- Hold rsp_ready = 0 for 5 cycles with a slave response pending → rsp_valid and data stay stable; slv_rsp_ready = 0. Raise rsp_ready → back-to-back retirement at 1 per cycle.
- Assert reset with 3 outstanding and rsp_valid = 1 → next cycle outstanding = 0, rsp_valid = 0, rsp_outputs_0 = 0. A new command issues normally afterwards.
- slv_int = 2'b10 → cmd_int = 1 in the same cycle; slv_int = 0 → cmd_int = 0.
